sha2_pad: RTL and testbench
===========================

SHA2_PAD -- requirements
Module: sha2_pad

Interface
REQ-001 Parameter LEN_W, default 32: width of the internal message byte counter; the length field is (bytes*8) zero-extended to 64 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 in_data  in  32  message word, big-endian; byte 0 = in_data[31:24].
REQ-005 in_valid  in  1  in_data/in_last/in_bytes valid.
REQ-006 in_ready  out  1  block accepts a word this cycle (transfer = in_valid & in_ready).
REQ-007 in_last  in  1  word is the final word of the message.
REQ-008 in_bytes  in  3  valid bytes in the final word, 1..4, MSB-aligned; ignored unless in_last.
REQ-009 chunk  out  512  padded 512-bit chunk; word 0 = chunk[511:480].
REQ-010 chunk_valid  out  1  chunk is presented.
REQ-011 chunk_ready  in  1  consumer takes chunk (transfer = chunk_valid & chunk_ready).
REQ-012 chunk_first  out  1  chunk is the first chunk of its message.
REQ-013 chunk_last  out  1  chunk is the final padded chunk of its message.

Function
REQ-014 States: FILL (in_ready=1, collecting words 0..15), EMIT (chunk_valid=1, in_ready=0), EXTRA (build the padding-only chunk, one cycle, then EMIT).
REQ-015 FILL: each accepted word is written to word index k (0..15); k increments; byte counter adds 4, or in_bytes on the last word.
REQ-016 Accepting word 15 without in_last: go to EMIT next cycle, chunk_last=0.
REQ-017 On the last word, bytes beyond in_bytes are forced to zero; byte 0x80 placed immediately after the last valid byte (same word if in_bytes<4, else word k+1); all following bytes zero.
REQ-018 If the 0x80 byte lands at word index <=13, words 14..15 = 64-bit length; go to EMIT with chunk_last=1.
REQ-019 Otherwise emit the current chunk with chunk_last=0, then EXTRA: all zeros, word 0 = 0x80000000 only if k=15 and in_bytes=4, words 14..15 = length; emitted with chunk_last=1.
REQ-020 chunk, chunk_first, chunk_last held stable while chunk_valid=1 and chunk_ready=0.
REQ-021 On chunk transfer: if chunk_last=0 and padding pending, go to EXTRA; if chunk_last=0 and none pending, return to FILL with k=0; if chunk_last=1, return to FILL with k=0, byte counter=0, first flag set.
REQ-022 chunk_first=1 only on the first chunk after reset or after a chunk_last transfer.
REQ-023 Latency: chunk_valid asserts the cycle after the transfer of the word completing the chunk; in_ready returns the cycle after the chunk transfer.
REQ-024 Byte counter wraps modulo 2^LEN_W; zero-length messages are unsupported (in_last always carries >=1 byte).
REQ-025 in_ready=0 in EMIT and EXTRA; in_valid in those states is ignored, no word consumed.

Reset
REQ-026 reset_n=0 at a clock edge: state=FILL, k=0, byte counter=0, first flag=1, chunk_valid=0, chunk_last=0, chunk=0; in_ready=1 after the first edge with reset_n=1.
REQ-027 Reset mid-message or mid-EMIT discards partial data and any pending chunk; no chunk from the aborted message is presented afterwards.

Structure
REQ-028 Shared package sha2_pkg holds the state enum, SHA2_CHUNK_W=512, SHA2_WORD_W=32, and the padding byte constant 8'h80.
REQ-029 Sub-module sha2_pad_mask: combinational last-word mask and 0x80 insertion from in_data/in_bytes; all other logic in sha2_pad.

Verification
REQ-030 "abc": one word 0x61626300, in_bytes=3, in_last -> one chunk, word0=0x61626380, words1..14=0, word15=0x00000018, first=1, last=1.
REQ-031 55 bytes (13 full words + 0x.. in_bytes=3) -> one chunk, 0x80 at byte 55, word15=0x000001B8, last=1.
REQ-032 56 bytes (14 full words) -> chunk 1 word14=0x80000000, word15=0, last=0; chunk 2 all zero except word15=0x000001C0, first=0, last=1.
REQ-033 64 bytes (16 full words) -> chunk 1 data, last=0; chunk 2 word0=0x80000000, word15=0x00000200, last=1.
REQ-034 Backpressure: chunk_ready=0 for 5 cycles after chunk_valid -> chunk and flags constant, in_ready=0, in_valid words not consumed; transfer on cycle 6.
REQ-035 reset_n=0 after word 7 of a message, then new "abc" -> single "abc" chunk as in REQ-030 with first=1; no stale words.

Source files
------------

// File: rtl/sha2_pkg.sv
// ============================================================================
// Module      : sha2_pkg
// Description : Shared types and constants for the SHA-2 message padder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha2_pkg;

    localparam int SHA2_CHUNK_W = 512;
    localparam int SHA2_WORD_W  = 32;
    localparam logic [7:0] SHA2_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_EXTRA = 2'd2
    } state_e;

    // Message length in bits as the 64-bit big-endian trailer value.
    function automatic logic [63:0] sha2_len_bits(input logic [63:0] bytes);
        return bytes << 3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha2_pad_mask.sv
// ============================================================================
// Module      : sha2_pad_mask
// Description : Masks unused bytes of the final word and inserts the 0x80 byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha2_pad_mask
    import sha2_pkg::*;
(
    input  logic [SHA2_WORD_W-1:0] in_data,
    input  logic [2:0]             in_bytes,
    input  logic                   in_last,
    output logic [SHA2_WORD_W-1:0] word_out,
    output logic [2:0]             eff_bytes,
    output logic                   pad_in_word
);

    always_comb begin
        eff_bytes   = in_bytes;
        word_out    = in_data;
        pad_in_word = 1'b0;
        // Out-of-range counts are treated as a full word.
        if ((in_bytes == 3'd0) || (in_bytes > 3'd4)) begin
            eff_bytes = 3'd4;
        end
        if (in_last) begin
            unique case (eff_bytes)
                3'd1: begin
                    word_out    = {in_data[31:24], SHA2_PAD_BYTE, 16'h0000};
                    pad_in_word = 1'b1;
                end
                3'd2: begin
                    word_out    = {in_data[31:16], SHA2_PAD_BYTE, 8'h00};
                    pad_in_word = 1'b1;
                end
                3'd3: begin
                    word_out    = {in_data[31:8], SHA2_PAD_BYTE};
                    pad_in_word = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha2_pad.sv
// ============================================================================
// Module      : sha2_pad
// Description : Packs a word stream into padded 512-bit SHA-2 message chunks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha2_pad
    import sha2_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SHA2_WORD_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [2:0]              in_bytes,
    output logic [SHA2_CHUNK_W-1:0] chunk,
    output logic                    chunk_valid,
    input  logic                    chunk_ready,
    output logic                    chunk_first,
    output logic                    chunk_last
);

    state_e                  state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic [LEN_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic                    first_q, first_d;
    logic                    in_ready_q, in_ready_d;
    logic                    chunk_valid_q, chunk_valid_d;
    logic                    chunk_last_q, chunk_last_d;
    logic                    chunk_first_q, chunk_first_d;
    logic                    extra_pending_q, extra_pending_d;
    logic                    extra_pad_q, extra_pad_d;
    logic [SHA2_CHUNK_W-1:0] chunk_q, chunk_d;

    logic [SHA2_WORD_W-1:0]  masked_word;
    logic [2:0]              eff_bytes;
    logic                    pad_in_word;
    logic                    accept;
    logic [LEN_W-1:0]        cnt_next;
    logic [4:0]              pad_idx;
    logic                    fits;
    logic [63:0]             len_new;
    logic [63:0]             len_cur;

    sha2_pad_mask u_mask (
        .in_data     (in_data),
        .in_bytes    (in_bytes),
        .in_last     (in_last),
        .word_out    (masked_word),
        .eff_bytes   (eff_bytes),
        .pad_in_word (pad_in_word)
    );

    assign accept   = in_valid & in_ready_q;
    assign cnt_next = byte_cnt_q + (in_last ? LEN_W'(eff_bytes) : LEN_W'(4));
    // Word index receiving the 0x80 byte; 16 means it spills into the extra chunk.
    assign pad_idx  = pad_in_word ? {1'b0, k_q} : ({1'b0, k_q} + 5'd1);
    assign fits     = in_last & (pad_idx <= 5'd13);
    assign len_new  = sha2_len_bits(64'(cnt_next));
    assign len_cur  = sha2_len_bits(64'(byte_cnt_q));

    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        byte_cnt_d      = byte_cnt_q;
        first_d         = first_q;
        in_ready_d      = in_ready_q;
        chunk_valid_d   = chunk_valid_q;
        chunk_last_d    = chunk_last_q;
        chunk_first_d   = chunk_first_q;
        extra_pending_d = extra_pending_q;
        extra_pad_d     = extra_pad_q;
        chunk_d         = chunk_q;

        unique case (state_q)
            ST_FILL: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    for (int i = 0; i < 16; i++) begin
                        if (i == int'(k_q)) begin
                            chunk_d[SHA2_CHUNK_W-1-32*i -: SHA2_WORD_W] = masked_word;
                        end else if (in_last && (i > int'(k_q))) begin
                            chunk_d[SHA2_CHUNK_W-1-32*i -: SHA2_WORD_W] =
                                (i == int'(pad_idx)) ? {SHA2_PAD_BYTE, 24'h000000} : '0;
                        end
                    end
                    if (fits) begin
                        chunk_d[63:0] = len_new;
                    end
                    k_d        = 4'(k_q + 4'd1);
                    byte_cnt_d = cnt_next;
                    if (in_last || (k_q == 4'd15)) begin
                        state_d         = ST_EMIT;
                        in_ready_d      = 1'b0;
                        chunk_valid_d   = 1'b1;
                        chunk_last_d    = fits;
                        chunk_first_d   = first_q;
                        extra_pending_d = in_last & ~fits;
                        extra_pad_d     = in_last & (k_q == 4'd15) & ~pad_in_word;
                    end
                end
            end
            ST_EMIT: begin
                in_ready_d = 1'b0;
                if (chunk_ready) begin
                    chunk_valid_d = 1'b0;
                    first_d       = chunk_last_q;
                    if (chunk_last_q) begin
                        state_d    = ST_FILL;
                        in_ready_d = 1'b1;
                        k_d        = 4'd0;
                        byte_cnt_d = '0;
                    end else if (extra_pending_q) begin
                        state_d = ST_EXTRA;
                    end else begin
                        state_d    = ST_FILL;
                        in_ready_d = 1'b1;
                        k_d        = 4'd0;
                    end
                end
            end
            ST_EXTRA: begin
                in_ready_d = 1'b0;
                chunk_d    = '0;
                if (extra_pad_q) begin
                    chunk_d[SHA2_CHUNK_W-1 -: SHA2_WORD_W] = {SHA2_PAD_BYTE, 24'h000000};
                end
                chunk_d[63:0]   = len_cur;
                chunk_valid_d   = 1'b1;
                chunk_last_d    = 1'b1;
                chunk_first_d   = first_q;
                extra_pending_d = 1'b0;
                extra_pad_d     = 1'b0;
                state_d         = ST_EMIT;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_FILL;
            k_q             <= 4'd0;
            byte_cnt_q      <= '0;
            first_q         <= 1'b1;
            in_ready_q      <= 1'b0;
            chunk_valid_q   <= 1'b0;
            chunk_last_q    <= 1'b0;
            chunk_first_q   <= 1'b0;
            extra_pending_q <= 1'b0;
            extra_pad_q     <= 1'b0;
            chunk_q         <= '0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            byte_cnt_q      <= byte_cnt_d;
            first_q         <= first_d;
            in_ready_q      <= in_ready_d;
            chunk_valid_q   <= chunk_valid_d;
            chunk_last_q    <= chunk_last_d;
            chunk_first_q   <= chunk_first_d;
            extra_pending_q <= extra_pending_d;
            extra_pad_q     <= extra_pad_d;
            chunk_q         <= chunk_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign chunk       = chunk_q;
    assign chunk_valid = chunk_valid_q;
    assign chunk_first = chunk_first_q;
    assign chunk_last  = chunk_last_q;

endmodule

`default_nettype wire

// File: tb/tb_sha2_pad.sv
// ============================================================================
// Module      : tb_sha2_pad
// Description : Directed vector bench for sha2_pad with a byte-level padding model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha2_pad;

    logic         clk;
    logic         reset_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         chunk_first;
    logic         chunk_last;

    int n_vec = 0;
    int n_err = 0;

    sha2_pad #(.LEN_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nbytes;
        int          nchunks;
        logic [31:0] c0w15;
        logic [31:0] c1w0;
        logic [31:0] c1w15;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [7:0] msg_byte(input int i);
        return 8'(8'h61 + i);
    endfunction

    function automatic logic [31:0] word_of(input logic [511:0] c, input int i);
        return 32'(c >> (32 * (15 - i)));
    endfunction

    // Reference SHA-2 padding built byte by byte.
    function automatic logic [511:0] ref_chunk(input int nbytes, input int j);
        logic [7:0]   pad [128];
        logic [63:0]  len;
        logic [511:0] r;
        int           total;
        total = ((nbytes + 72) / 64) * 64;
        for (int i = 0; i < 128; i++) pad[i] = 8'h00;
        for (int i = 0; i < nbytes; i++) pad[i] = msg_byte(i);
        pad[nbytes] = 8'h80;
        len = 64'(nbytes) * 64'd8;
        for (int b = 0; b < 8; b++) pad[total - 1 - b] = 8'(len >> (8 * b));
        r = '0;
        for (int i = 0; i < 64; i++) r[511 - 8 * i -: 8] = pad[64 * j + i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: actual no handshake, required handshake within budget", name);
    endtask

    task automatic send_msg(input int nbytes, input bit with_last);
        int nw;
        int guard;
        nw = (nbytes + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                in_data[31 - 8 * j -: 8] = (4 * w + j < nbytes) ? msg_byte(4 * w + j) : 8'hEE;
            end
            in_valid = 1'b1;
            in_last  = with_last && (w == nw - 1);
            in_bytes = in_last ? 3'(nbytes - 4 * w) : 3'd1;
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                fail_timeout($sformatf("in_ready wait word %0d", w));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int v);
        int guard;
        for (int j = 0; j < vecs[v].nchunks; j++) begin
            @(negedge clk);
            guard = 0;
            while (!chunk_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!chunk_valid) begin
                fail_timeout($sformatf("v%0d chunk %0d valid", v, j));
                return;
            end
            chk($sformatf("v%0d c%0d data", v, j), chunk, ref_chunk(vecs[v].nbytes, j));
            chk($sformatf("v%0d c%0d first", v, j), 512'(chunk_first), 512'(j == 0));
            chk($sformatf("v%0d c%0d last", v, j), 512'(chunk_last), 512'(j == vecs[v].nchunks - 1));
            if (j == 0) chk($sformatf("v%0d c0 w15", v), 512'(word_of(chunk, 15)), 512'(vecs[v].c0w15));
            if (j == 1) begin
                chk($sformatf("v%0d c1 w0", v), 512'(word_of(chunk, 0)), 512'(vecs[v].c1w0));
                chk($sformatf("v%0d c1 w15", v), 512'(word_of(chunk, 15)), 512'(vecs[v].c1w15));
            end
        end
    endtask

    task automatic run_vec(input int v);
        fork
            send_msg(vecs[v].nbytes, 1'b1);
            collect(v);
        join
        @(negedge clk);
        chk($sformatf("v%0d idle valid", v), 512'(chunk_valid), 512'(0));
        chk($sformatf("v%0d idle ready", v), 512'(in_ready), 512'(1));
    endtask

    logic [511:0] held;

    initial begin
        vecs[0] = '{nbytes: 3,  nchunks: 1, c0w15: 32'h00000018, c1w0: 32'h0, c1w15: 32'h0};
        vecs[1] = '{nbytes: 1,  nchunks: 1, c0w15: 32'h00000008, c1w0: 32'h0, c1w15: 32'h0};
        vecs[2] = '{nbytes: 55, nchunks: 1, c0w15: 32'h000001B8, c1w0: 32'h0, c1w15: 32'h0};
        vecs[3] = '{nbytes: 56, nchunks: 2, c0w15: 32'h00000000, c1w0: 32'h0,        c1w15: 32'h000001C0};
        vecs[4] = '{nbytes: 64, nchunks: 2, c0w15: 32'h9D9E9FA0, c1w0: 32'h80000000, c1w15: 32'h00000200};
        vecs[5] = '{nbytes: 60, nchunks: 2, c0w15: 32'h80000000, c1w0: 32'h0,        c1w15: 32'h000001E0};
        vecs[6] = '{nbytes: 57, nchunks: 2, c0w15: 32'h00000000, c1w0: 32'h0,        c1w15: 32'h000001C8};
        vecs[7] = '{nbytes: 65, nchunks: 2, c0w15: 32'h9D9E9FA0, c1w0: 32'hA1800000, c1w15: 32'h00000208};

        reset_n     = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_bytes    = 3'd0;
        chunk_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset chunk_valid", 512'(chunk_valid), 512'(0));
        chk("reset chunk_last", 512'(chunk_last), 512'(0));
        chk("reset chunk", chunk, 512'(0));
        chk("reset in_ready", 512'(in_ready), 512'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 512'(in_ready), 512'(1));

        for (int v = 0; v < 8; v++) run_vec(v);

        // Backpressure: "abc" held for five cycles while a stray word is offered.
        chunk_ready = 1'b0;
        in_data  = 32'h61626300;
        in_bytes = 3'd3;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 32'h41000000;
        in_bytes = 3'd1;
        chk("bp latency valid", 512'(chunk_valid), 512'(1));
        held = ref_chunk(3, 0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d chunk", c), chunk, held);
            chk($sformatf("bp%0d flags", c), 512'({chunk_valid, chunk_first, chunk_last, in_ready}), 512'(4'b1110));
            @(negedge clk);
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        chunk_ready = 1'b1;
        chk("bp final chunk", chunk, held);
        @(negedge clk);
        chk("bp after valid", 512'(chunk_valid), 512'(0));
        chk("bp after in_ready", 512'(in_ready), 512'(1));
        repeat (3) @(negedge clk);
        chk("bp stray not consumed", 512'(chunk_valid), 512'(0));

        // Abort after word 7, then a fresh "abc".
        send_msg(32, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort chunk_valid", 512'(chunk_valid), 512'(0));
        chk("abort in_ready", 512'(in_ready), 512'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort in_ready back", 512'(in_ready), 512'(1));
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
